// File: rtl/axi_ram_pkg.sv
// rtl/axi_ram_pkg.sv - shared op codes, FSM states and field offsets for the stream RAM
package axi_ram_pkg;

  localparam logic OP_WR = 1'b0;
  localparam logic OP_RD = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Data sits in the low bits of both command and response words.
  localparam int DATA_LSB = 0;

  // The address field starts right above the data field.
  function automatic int addr_lsb(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  // The op bit is the MSB of the command word.
  function automatic int op_bit(input int addr_w, input int data_w);
    return addr_lsb(data_w) + addr_w;
  endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// rtl/axi_ram_mem.sv - storage array, one write port and two registered read-first read ports
module axi_ram_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Array write; the array itself is never reset, the clear sweep handles that.
  always_ff @(posedge aclk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read registers see the pre-write contents when a write hits the same address.
  always_ff @(posedge aclk) begin
    if (areset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) a_rdata <= mem_q[a_addr];
      if (b_en) b_rdata <= mem_q[b_addr];
    end
  end

endmodule

// File: rtl/axi_stream_ram_rw.sv
// rtl/axi_stream_ram_rw.sv - stream-addressed RAM with clear sweep, debug port, optional counters (AXI_RAM_ACCESS_CNT_EN)
module axi_stream_ram_rw
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CMD_W  = 1 + ADDR_W + DATA_W,
  parameter int RSP_W  = ADDR_W + DATA_W
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [CMD_W-1:0]  s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [RSP_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  input  logic [ADDR_W-1:0] debug_addr,
  input  logic              debug_rd_en,
  output logic [DATA_W-1:0] debug_rdata,
  output logic              busy
`ifdef AXI_RAM_ACCESS_CNT_EN
  ,
  output logic [31:0]       wr_count,
  output logic [31:0]       rd_count
`endif
);

  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int OP_BIT   = op_bit(ADDR_W, DATA_W);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] rsp_addr_q;
  logic [DATA_W-1:0] rsp_data;

  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_fire, wr_fire, rd_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign cmd_op   = s_axis_tdata[OP_BIT];
  assign cmd_addr = s_axis_tdata[ADDR_LSB +: ADDR_W];
  assign cmd_data = s_axis_tdata[DATA_LSB +: DATA_W];

  // Ready only looks at state and the output stage so it cannot loop back through tvalid.
  assign s_axis_tready = (state_q == ST_RUN) && (!m_axis_tvalid || m_axis_tready);
  assign cmd_fire      = s_axis_tvalid && s_axis_tready;
  assign wr_fire       = cmd_fire && (cmd_op == OP_WR);
  assign rd_fire       = cmd_fire && (cmd_op == OP_RD);
  assign busy          = (state_q == ST_CLEAR);

  // The sweep owns the write port while clearing; afterwards it belongs to stream writes.
  assign mem_we    = busy || wr_fire;
  assign mem_waddr = busy ? clr_ptr_q : cmd_addr;
  assign mem_wdata = busy ? '0 : cmd_data;

  // State register and clear pointer.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (busy) clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
    end
  end

  // Leave CLEAR once the last address has been written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_ptr_q == '1) state_d = ST_RUN;
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // Response stage: load on an accepted read, drop on a consumed response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      rsp_addr_q    <= '0;
    end else if (rd_fire) begin
      m_axis_tvalid <= 1'b1;
      rsp_addr_q    <= cmd_addr;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  assign m_axis_tdata = {rsp_addr_q, rsp_data};

  axi_ram_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .aclk    (aclk),
    .areset  (areset),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .a_en    (rd_fire),
    .a_addr  (cmd_addr),
    .a_rdata (rsp_data),
    .b_en    (debug_rd_en),
    .b_addr  (debug_addr),
    .b_rdata (debug_rdata)
  );

`ifdef AXI_RAM_ACCESS_CNT_EN
  // Saturating access counters; sweep writes never reach wr_fire.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_fire && (wr_count != '1)) wr_count <= wr_count + 32'd1;
      if (rd_fire && (rd_count != '1)) rd_count <= rd_count + 32'd1;
    end
  end
`else
  // No access counters in this build.
`endif

endmodule

// File: doc/axi_stream_ram_rw.md
Name: axi_stream_ram_rw

Overview:
- Parametrised AXI-Stream-addressed RAM, next generation of the stream-fed scratch RAM.
- Command stream carries both writes and reads. Read responses return on a master stream with full backpressure.
- Performs a hardware clear sweep after reset. Keeps a non-blocking debug read port.
- Sits between the stream fabric (DMA/core command path) and the debug bus.

Parameters:
- ADDR_W, 8, address bits; depth = 2**ADDR_W words.
- DATA_W, 8, word width in bits.
- CMD_W, 1+ADDR_W+DATA_W, derived command width; do not override.
- RSP_W, ADDR_W+DATA_W, derived response width; do not override.

Ports:
- aclk  in  1  single clock, all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  CMD_W  command {op[CMD_W-1], addr[ADDR_W+DATA_W-1:DATA_W], data[DATA_W-1:0]}; op 0 = write, 1 = read.
- s_axis_tvalid  in  1  command valid.
- s_axis_tready  out  1  command accepted when tvalid & tready.
- m_axis_tdata  out  RSP_W  read response {addr, data}.
- m_axis_tvalid  out  1  response valid.
- m_axis_tready  in  1  response consumer ready.
- debug_addr  in  ADDR_W  debug read address.
- debug_rd_en  in  1  debug read strobe.
- debug_rdata  out  DATA_W  registered debug data.
- busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (areset=1 at an edge):
  - m_axis_tvalid=0, m_axis_tdata=0, debug_rdata=0, busy=1.
  - FSM enters CLEAR; clear pointer=0.
  - Reset mid-operation discards any pending response (tvalid drops on the next edge) and restarts the sweep from 0.
- FSM states:
  - CLEAR: write 0 to mem[ptr], ptr+1 each cycle. After writing the last address (2**ADDR_W-1) go to RUN. Sweep takes exactly 2**ADDR_W cycles after reset deasserts.
  - RUN: busy=0; serves commands.
- s_axis_tready = (state==RUN) & (!m_axis_tvalid | m_axis_tready). This is combinational from state and output stage only; it never depends on tdata or tvalid.
- Write (op=0) accepted: mem[addr] <= data at that edge. No response generated. Sustains 1 command per cycle (no idle ACK cycle).
- Read (op=1) accepted:
  - Synchronous read; m_axis_tvalid=1 on the next edge with tdata={addr, mem[addr]}.
  - Read latency 1 cycle; throughput 1/cycle while m_axis_tready=1.
- Response hold: while tvalid & !tready, m_axis_tdata is stable, s_axis_tready=0, and no command of either op is accepted.
- Response retire: on tvalid & tready with no new read accepted in the same cycle, tvalid goes 0 on that edge.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Debug read:
  - debug_rd_en=1 -> debug_rdata <= mem[debug_addr] on the next edge. Holds its value otherwise.
  - Independent of stream handshakes. Not blocked in CLEAR (returns the current, possibly partially cleared, contents).
  - Debug read and stream write to the same address in the same cycle -> debug returns the old data.
- Address wrap: addresses are exactly ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro: AXI_RAM_ACCESS_CNT_EN.
- Defined: adds outputs wr_count[31:0] and rd_count[31:0].
  - wr_count increments per accepted write; rd_count increments per accepted read.
  - Both saturate at 32'hFFFFFFFF. Both cleared by areset. Clear-sweep writes are not counted.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package axi_ram_pkg:
  - OP_WR=1'b0, OP_RD=1'b1.
  - FSM encodings ST_CLEAR, ST_RUN.
  - Field-offset localparams for the command/response layouts.
- Sub-module axi_ram_mem: storage with 1 synchronous write port and 2 synchronous read ports (stream, debug), no reset on the array.
- Top holds the FSM, clear pointer, handshake and counters.

Test Plan:
- Reset, then hold areset=0: busy=1 for exactly 256 cycles, s_axis_tready=0 throughout; then busy=0, tready=1. Debug reads of 0x00 and 0xFF return 0x00.
- Write {0,0x10,0xA5} then read {1,0x10,xx} back-to-back, m_axis_tready=1 -> m_axis_tdata=0x10A5 one cycle after the read is accepted.
- Four reads (addr 0x01..0x04, data 0x11..0x44) with m_axis_tready=0 for 3 cycles after the first response -> first response held stable, tready=0, no loss or duplication; responses 0x0111,0x0222,0x0333,0x0444 in order.
- Same-cycle stream write 0x20<=0x5A and debug read of 0x20 (prior value 0x00) -> debug_rdata=0x00; a debug read the next cycle -> 0x5A.
- areset asserted while a response is pending -> tvalid=0 after the edge; re-sweep runs; addr 0x10 reads 0x00 afterwards.
- With AXI_RAM_ACCESS_CNT_EN: 3 writes and 2 reads -> wr_count=3, rd_count=2. Force rd_count to 32'hFFFFFFFF, issue one more read -> rd_count stays 32'hFFFFFFFF.
